// File: rtl/regfile_sb_pkg.sv
// rf_pkg: shared constants and helpers for the regfile_sb register file.
//   RF_DATA_W / RF_ADDR_W : default data and select widths
//   RF_ZERO               : index of the hardwired zero register
//   slice_off()           : bit offset of packed port i for a given field width
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_ZERO   = 0;

    function automatic int unsigned slice_off(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the register file.
//   rd_sel   : NRD packed read selects        rd_data : NRD packed read data
//   rd_busy  : per-port busy bit              busy_cnt: registered busy count
//   wr_en/wr_sel/wr_data : writeback          iss_en/iss_sel : issue (mark pending)
// master = pipeline side, slave = register file side.
interface regfile_sb_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NRD    = 2
);

    logic [NRD*ADDR_W-1:0] rd_sel;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_sel;
    logic [DATA_W-1:0]     wr_data;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_sel;
    logic [ADDR_W:0]       busy_cnt;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking.
//   clk, rst_n            : clock, synchronous active-low reset
//   wr_en_i / wr_sel_i    : writeback clears the busy bit
//   iss_en_i / iss_sel_i  : issue sets the busy bit (wins over a same-cycle clear)
//   busy_o                : busy vector, one bit per register
//   busy_cnt_o            : registered popcount of busy_o
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_sel_i,
    input  logic                    iss_en_i,
    input  logic [ADDR_W-1:0]       iss_sel_i,
    output logic [(2**ADDR_W)-1:0]  busy_o,
    output logic [ADDR_W:0]         busy_cnt_o
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             wr_ok, iss_ok;

    assign wr_ok  = wr_en_i  && !((ZERO_REG != 0) && (wr_sel_i  == ADDR_W'(RF_ZERO)));
    assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_sel_i == ADDR_W'(RF_ZERO)));

    // Clear first, then set, so a same-cycle issue to the written register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)  busy_d[wr_sel_i]  = 1'b0;
        if (iss_ok) busy_d[iss_sel_i] = 1'b1;
        cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-port register file with hardwired zero
// register, optional write-to-read bypass and a busy scoreboard.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : regfile_sb_if.slave (reads, writeback, issue, busy_cnt)
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]      busy_vec;
    logic                  wr_ok, iss_ok;
    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_busy_c;

    assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_sel  == ADDR_W'(RF_ZERO)));
    assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_sel == ADDR_W'(RF_ZERO)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[bus.wr_sel] <= bus.wr_data;
        end
    end

    // Each port resolves independently; the zero register overrides bypass,
    // and a forwarded write is not pending unless it is re-issued this cycle.
    always_comb begin
        logic [ADDR_W-1:0] sel;
        logic              hit;
        rd_data_c = '0;
        rd_busy_c = '0;
        sel       = '0;
        hit       = 1'b0;
        for (int unsigned p = 0; p < NRD; p++) begin
            sel = bus.rd_sel[slice_off(p, ADDR_W) +: ADDR_W];
            hit = (BYPASS != 0) && wr_ok && (bus.wr_sel == sel);
            if ((ZERO_REG != 0) && (sel == ADDR_W'(RF_ZERO))) begin
                rd_data_c[slice_off(p, DATA_W) +: DATA_W] = '0;
            end else if (hit) begin
                rd_data_c[slice_off(p, DATA_W) +: DATA_W] = bus.wr_data;
            end else begin
                rd_data_c[slice_off(p, DATA_W) +: DATA_W] = mem_q[sel];
            end
            rd_busy_c[p] = busy_vec[sel] && !(hit && !(iss_ok && (bus.iss_sel == sel)));
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (bus.wr_en),
        .wr_sel_i   (bus.wr_sel),
        .iss_en_i   (bus.iss_en),
        .iss_sel_i  (bus.iss_sel),
        .busy_o     (busy_vec),
        .busy_cnt_o (bus.busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives a bypassing and a non-bypassing regfile_sb with the
// same stimulus; expectations come from an array/flag model of the register
// file and are checked by a negedge monitor through a queue.
module tb_regfile_sb;
    import rf_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 3;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus_b ();
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus_nb ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1), .BYPASS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1), .BYPASS(0))
        dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));

    typedef struct {
        logic [NR*DW-1:0] db;
        logic [NR*DW-1:0] dnb;
        logic [NR-1:0]    bb;
        logic [NR-1:0]    bnb;
        logic [AW:0]      cnt;
        int unsigned      tag;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model: plain register array plus pending flags.
    logic [DW-1:0] mem [DEPTH];
    bit            pend [DEPTH];
    bit            model_ok = 0;
    int unsigned   tag_n = 0;

    function automatic int unsigned pend_count();
        int unsigned n = 0;
        for (int i = 1; i < DEPTH; i++) n += pend[i] ? 1 : 0;
        return n;
    endfunction

    task automatic chk(input string name, input int unsigned tag,
                       input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s tag=%0d got=%h expected=%h", name, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd_data_byp",   e.tag, bus_b.rd_data,  e.db);
            chk("rd_data_nobyp", e.tag, bus_nb.rd_data, e.dnb);
            chk("rd_busy_byp",   e.tag, (NR*DW)'(bus_b.rd_busy),  (NR*DW)'(e.bb));
            chk("rd_busy_nobyp", e.tag, (NR*DW)'(bus_nb.rd_busy), (NR*DW)'(e.bnb));
            chk("busy_cnt_byp",  e.tag, (NR*DW)'(bus_b.busy_cnt),  (NR*DW)'(e.cnt));
            chk("busy_cnt_nobyp",e.tag, (NR*DW)'(bus_nb.busy_cnt), (NR*DW)'(e.cnt));
        end
    end

    // Drive one cycle, queue the pre-edge expectation, then apply the edge to the model.
    task automatic step(input bit rs, input bit we, input int unsigned ws, input logic [DW-1:0] wd,
                        input bit ie, input int unsigned is,
                        input int unsigned s0, input int unsigned s1, input int unsigned s2);
        int unsigned   sel [NR];
        logic [NR*AW-1:0] sv;
        exp_t e;
        sel[0] = s0; sel[1] = s1; sel[2] = s2;
        sv = '0;
        for (int p = 0; p < NR; p++) sv[p*AW +: AW] = AW'(sel[p]);
        rst_n = rs;
        bus_b.rd_sel  = sv;  bus_nb.rd_sel  = sv;
        bus_b.wr_en   = we;  bus_nb.wr_en   = we;
        bus_b.wr_sel  = AW'(ws); bus_nb.wr_sel = AW'(ws);
        bus_b.wr_data = wd;  bus_nb.wr_data = wd;
        bus_b.iss_en  = ie;  bus_nb.iss_en  = ie;
        bus_b.iss_sel = AW'(is); bus_nb.iss_sel = AW'(is);
        if (model_ok) begin
            e.tag = tag_n;
            e.cnt = (AW+1)'(pend_count());
            e.db = '0; e.dnb = '0; e.bb = '0; e.bnb = '0;
            for (int p = 0; p < NR; p++) begin
                int unsigned s;
                bit fwd;
                s = sel[p];
                fwd = we && (ws == s) && (s != 0);
                if (s != 0) begin
                    e.dnb[p*DW +: DW] = mem[s];
                    e.db[p*DW +: DW]  = fwd ? wd : mem[s];
                    e.bnb[p] = pend[s];
                    e.bb[p]  = pend[s] && !(fwd && !(ie && is == s));
                end
            end
            q.push_back(e);
        end
        tag_n++;
        @(posedge clk);
        #1;
        if (!rs) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = '0;
                pend[i] = 0;
            end
            model_ok = 1;
        end else begin
            if (we && ws != 0) begin
                mem[ws] = wd;
                pend[ws] = 0;
            end
            if (ie && is != 0) pend[is] = 1;
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        step(0, 0, 0, '0, 0, 0, 0, 0, 0);

        // Reset state on every register, rotated across ports.
        for (int unsigned r = 0; r < DEPTH; r++)
            step(1, 0, 0, '0, 0, 0, r, (r + 1) % DEPTH, (r + 2) % DEPTH);

        // Write sweep including register 0, then read back.
        for (int unsigned r = 0; r < DEPTH; r++)
            step(1, 1, r, 32'hAFAF_AFAF, 0, 0, r, r, r);
        for (int unsigned r = 0; r < DEPTH; r++)
            step(1, 0, 0, '0, 0, 0, r, r, r);

        // Same-cycle read/write of register 1.
        step(1, 1, 1, 32'h0101_0101, 0, 0, 1, 1, 1);
        step(1, 0, 0, '0, 0, 0, 1, 1, 1);

        // Scoreboard: issue 5, 7, 0; write 5 while reading it.
        step(1, 0, 0, '0, 1, 5, 5, 7, 0);
        step(1, 0, 0, '0, 1, 7, 5, 7, 0);
        step(1, 0, 0, '0, 1, 0, 5, 7, 0);
        step(1, 0, 0, '0, 0, 0, 5, 7, 0);
        step(1, 1, 5, 32'h5555_0005, 0, 0, 5, 7, 0);
        step(1, 0, 0, '0, 0, 0, 5, 7, 0);

        // Issue and write 9 together while it is already busy.
        step(1, 0, 0, '0, 1, 9, 9, 9, 9);
        step(1, 1, 9, 32'h9999_0009, 1, 9, 9, 9, 9);
        step(1, 0, 0, '0, 0, 0, 9, 9, 9);

        // Reset in the middle of pending work.
        step(1, 1, 3, 32'h1234_5678, 1, 3, 3, 4, 0);
        step(1, 0, 0, '0, 1, 4, 3, 4, 0);
        step(1, 0, 0, '0, 0, 0, 3, 4, 0);
        step(0, 1, 3, 32'hDEAD_BEEF, 1, 4, 3, 4, 0);
        step(1, 0, 0, '0, 0, 0, 3, 4, 0);

        // Random traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            bit          rs, we, ie;
            int unsigned ws, is, s0, s1, s2;
            rs = ($urandom_range(0, 39) != 0);
            we = $urandom_range(0, 1);
            ie = $urandom_range(0, 2) != 0;
            ws = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            is = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            s0 = $urandom_range(0, 7);
            s1 = $urandom_range(0, 7);
            s2 = $urandom_range(0, 31);
            step(rs, we, ws, $urandom, ie, is, s0, s1, s2);
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
